// File: rtl/mac_job_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_job_sequencer_if
//  Purpose  : Groups the handshake buses around the MAC job sequencer:
//             job command, operand stream, MAC request/response and job
//             result, plus the busy status flag.
//  Modports : master - the environment (operand feeder, MAC unit, consumer)
//             slave  - the sequencer itself
//  Revision : 1.0 - initial release
// ============================================================================
interface mac_job_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
);
  // job command
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  // operand pair stream
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  // MAC request
  logic             mac_in_valid;
  logic             mac_in_ready;
  logic [WIDTH-1:0] mac_x;
  logic [WIDTH-1:0] mac_y;
  logic [WIDTH-1:0] mac_x2;
  logic [WIDTH-1:0] mac_y2;
  // MAC response
  logic             mac_out_valid;
  logic             mac_out_ready;
  logic [WIDTH-1:0] mac_result;
  // job result
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  // status
  logic             busy;

  modport master (
    output cmd_valid, cmd_len, input cmd_ready,
    output op_valid, op_a, op_b, input op_ready,
    input  mac_in_valid, mac_x, mac_y, mac_x2, mac_y2, output mac_in_ready,
    output mac_out_valid, mac_result, input mac_out_ready,
    input  res_valid, res_data, output res_ready,
    input  busy
  );

  modport slave (
    input  cmd_valid, cmd_len, output cmd_ready,
    input  op_valid, op_a, op_b, output op_ready,
    output mac_in_valid, mac_x, mac_y, mac_x2, mac_y2, input mac_in_ready,
    input  mac_out_valid, mac_result, output mac_out_ready,
    output res_valid, res_data, input res_ready,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/mac_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mac_job_sequencer
//  Purpose  : Sequences dot-product jobs onto a shared 2-lane MAC
//             (x*y + x2*y2). A job command gives the number of operand
//             pairs; pairs are packed two per MAC operation (an odd tail
//             pads x2/y2 with zero), partial sums are accumulated modulo
//             2^WIDTH and one result is returned per job.
//  Ports    : clock, reset (synchronous, active-high)
//             bus (mac_job_sequencer_if.slave): cmd_*, op_*, mac_in_*,
//             mac_x/y/x2/y2, mac_out_*, mac_result, res_*, busy
//  Options  : MAC_SEQ_RELU_EN - when defined, res_data is clamped to 0 if
//             the accumulator is negative as two's complement.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_job_sequencer #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
) (
  input wire                  clock,
  input wire                  reset,
  mac_job_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD0 = 3'd1,
    S_LOAD1 = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_x2;
  logic [WIDTH-1:0] r_y2;
  logic [WIDTH-1:0] w_res;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_acc       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_x2        <= '0;
      r_y2        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_remaining <= bus.cmd_len;
            r_acc       <= '0;
            if (bus.cmd_len == '0) r_state <= S_DONE;
            else                   r_state <= S_LOAD0;
          end
        end
        S_LOAD0: begin
          if (bus.op_valid) begin
            r_x         <= bus.op_a;
            r_y         <= bus.op_b;
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              // odd tail: second lane contributes nothing
              r_x2    <= '0;
              r_y2    <= '0;
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_LOAD1;
            end
          end
        end
        S_LOAD1: begin
          if (bus.op_valid) begin
            r_x2        <= bus.op_a;
            r_y2        <= bus.op_b;
            r_remaining <= r_remaining - LEN_W'(1);
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.mac_in_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mac_out_valid) begin
            r_acc <= r_acc + bus.mac_result;
            if (r_remaining == '0) r_state <= S_DONE;
            else                   r_state <= S_LOAD0;
          end
        end
        S_DONE: begin
          if (bus.res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MAC_SEQ_RELU_EN
  assign w_res = r_acc[WIDTH-1] ? '0 : r_acc;
`else
  assign w_res = r_acc;
`endif

  // Handshake outputs depend on the state register only.
  assign bus.cmd_ready     = (r_state == S_IDLE);
  assign bus.op_ready      = (r_state == S_LOAD0) || (r_state == S_LOAD1);
  assign bus.mac_in_valid  = (r_state == S_ISSUE);
  assign bus.mac_out_ready = (r_state == S_WAIT);
  assign bus.res_valid     = (r_state == S_DONE);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.res_data      = w_res;
  assign bus.mac_x         = r_x;
  assign bus.mac_y         = r_y;
  assign bus.mac_x2        = r_x2;
  assign bus.mac_y2        = r_y2;

endmodule
`default_nettype wire

// File: tb/tb_mac_job_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mac_job_sequencer
//  Purpose  : Scoreboard bench for mac_job_sequencer. Directed jobs push
//             their expected MAC operand sets and job results into queues;
//             a monitor pops and compares on each MAC request and result
//             handshake. A behavioural MAC with fixed latency answers
//             requests.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_job_sequencer;
  localparam int WIDTH   = 32;
  localparam int LEN_W   = 16;
  localparam int MAC_LAT = 2;
  localparam int BUDGET  = 200;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] y2;
  } mac_op_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mac_job_sequencer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  mac_job_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  mac_op_t          mac_q[$];
  logic [WIDTH-1:0] res_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int ops_seen    = 0;
  int opr_cycles  = 0;
  int miv_cycles  = 0;
  int res_seen    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out after %0d cycles, expected handshake", name, BUDGET);
  endtask

  // ---------------- behavioural MAC ----------------
  logic             m_in_f, m_out_f, m_rst, m_busy;
  logic [WIDTH-1:0] m_res;
  int               m_cnt;
  initial begin
    m_busy = 0; m_cnt = 0; m_res = '0;
    bus.mac_in_ready  = 1'b1;
    bus.mac_out_valid = 1'b0;
    bus.mac_result    = '0;
    forever begin
      @(negedge clock);
      m_in_f  = bus.mac_in_valid && bus.mac_in_ready;
      m_out_f = bus.mac_out_valid && bus.mac_out_ready;
      m_rst   = reset;
      if (m_in_f) m_res = bus.mac_x * bus.mac_y + bus.mac_x2 * bus.mac_y2;
      @(posedge clock); #1;
      if (m_rst) begin
        m_busy = 0; m_cnt = 0;
        bus.mac_out_valid = 1'b0;
        bus.mac_in_ready  = 1'b1;
      end else begin
        if (m_out_f) begin
          bus.mac_out_valid = 1'b0;
          bus.mac_in_ready  = 1'b1;
          m_busy = 0;
        end
        if (m_in_f) begin
          m_busy = 1; m_cnt = MAC_LAT;
          bus.mac_in_ready = 1'b0;
        end else if (m_busy && !bus.mac_out_valid && m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            bus.mac_out_valid = 1'b1;
            bus.mac_result    = m_res;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  mac_op_t          mon_op, mon_exp_op;
  logic [WIDTH-1:0] mon_exp_res;
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.op_ready)     opr_cycles++;
        if (bus.mac_in_valid) miv_cycles++;
        if (bus.mac_in_valid && bus.mac_in_ready) begin
          ops_seen++;
          mon_op = '{bus.mac_x, bus.mac_y, bus.mac_x2, bus.mac_y2};
          if (mac_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL mac_unexpected: got op %0h, expected no MAC request", mon_op);
          end else begin
            mon_exp_op = mac_q.pop_front();
            check("mac_operands", mon_op, mon_exp_op);
          end
        end
        if (bus.res_valid && bus.res_ready) begin
          res_seen++;
          if (res_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL res_unexpected: got %0h, expected no result", bus.res_data);
          end else begin
            mon_exp_res = res_q.pop_front();
            check("res_data", bus.res_data, mon_exp_res);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_cmd(input logic [LEN_W-1:0] len);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len;
    do begin @(negedge clock); n++; end while (!bus.cmd_ready && n < BUDGET);
    if (!bus.cmd_ready) timeout_fail("cmd_handshake");
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
  endtask

  task automatic send_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge clock); #1; end
    bus.op_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    do begin @(negedge clock); n++; end while (!bus.op_ready && n < BUDGET);
    if (!bus.op_ready) timeout_fail("op_handshake");
    @(posedge clock); #1;
    bus.op_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
  endtask

  task automatic wait_res(input int target);
    int n = 0;
    while (res_seen < target && n < BUDGET) begin @(negedge clock); n++; end
    if (res_seen < target) timeout_fail("res_wait");
    @(posedge clock); #1;
  endtask

  int base, hold_bad, n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 0; bus.cmd_len = '0;
    bus.op_valid  = 0; bus.op_a = '0; bus.op_b = '0;
    bus.res_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_handshakes", {bus.op_ready, bus.mac_in_valid, bus.mac_out_ready, bus.res_valid, bus.busy}, 5'b0);
    check("rst_data", {bus.res_data, bus.mac_x, bus.mac_y, bus.mac_x2, bus.mac_y2}, '0);
    @(posedge clock); #1;
    reset = 1'b0;

    // len=4: two full MAC ops, 2+12+30+56 = 100
    ops_seen = 0; base = res_seen;
    mac_q.push_back('{32'd1, 32'd2, 32'd3, 32'd4});
    mac_q.push_back('{32'd5, 32'd6, 32'd7, 32'd8});
    res_q.push_back(32'd100);
    send_cmd(16'd4);
    send_op(32'd1, 32'd2, 0); send_op(32'd3, 32'd4, 0);
    send_op(32'd5, 32'd6, 0); send_op(32'd7, 32'd8, 0);
    wait_res(base + 1);
    repeat (3) @(negedge clock);
    check("len4_mac_ops", ops_seen, 2);
    check("len4_one_result", res_seen - base, 1);
    @(posedge clock); #1;

    // len=3 with operand gaps: odd tail pads x2/y2, 6+20+42 = 68
    ops_seen = 0; base = res_seen;
    mac_q.push_back('{32'd2, 32'd3, 32'd4, 32'd5});
    mac_q.push_back('{32'd6, 32'd7, 32'd0, 32'd0});
    res_q.push_back(32'd68);
    send_cmd(16'd3);
    send_op(32'd2, 32'd3, 0); send_op(32'd4, 32'd5, 2); send_op(32'd6, 32'd7, 1);
    wait_res(base + 1);
    check("len3_mac_ops", ops_seen, 2);

    // len=0: straight to DONE with result 0
    ops_seen = 0; opr_cycles = 0; miv_cycles = 0; base = res_seen;
    res_q.push_back(32'd0);
    send_cmd(16'd0);
    @(negedge clock);
    check("len0_res_valid_next", {bus.res_valid, bus.res_data}, {1'b1, 32'd0});
    wait_res(base + 1);
    check("len0_no_op_ready", opr_cycles, 0);
    check("len0_no_mac_valid", miv_cycles, 0);

    // len=2 with back-pressured result
    bus.res_ready = 1'b0; base = res_seen;
    mac_q.push_back('{32'd1, 32'd2, 32'd3, 32'd4});
    res_q.push_back(32'd14);
    send_cmd(16'd2);
    send_op(32'd1, 32'd2, 0); send_op(32'd3, 32'd4, 0);
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.res_valid && n < BUDGET);
    if (!bus.res_valid) timeout_fail("hold_res_valid");
    hold_bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (!(bus.res_valid && bus.res_data == 32'd14 && !bus.cmd_ready)) hold_bad++;
    end
    check("hold_stable", hold_bad, 0);
    @(posedge clock); #1;
    bus.res_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("hold_idle_after", {bus.cmd_ready, bus.busy, bus.res_valid}, 3'b100);
    check("hold_one_result", res_seen - base, 1);
    @(posedge clock); #1;

    // len=4 abandoned by reset during WAIT of the first op
    base = res_seen;
    mac_q.push_back('{32'd1, 32'd2, 32'd3, 32'd4});
    send_cmd(16'd4);
    send_op(32'd1, 32'd2, 0); send_op(32'd3, 32'd4, 0);
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.mac_out_ready && n < BUDGET);
    if (!bus.mac_out_ready) timeout_fail("reset_wait_state");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_idle", {bus.busy, bus.cmd_ready, bus.res_valid}, 3'b010);
    repeat (5) @(negedge clock);
    check("rst_mid_no_result", res_seen - base, 0);
    check("rst_mid_first_op_issued", mac_q.size(), 0);
    @(posedge clock); #1;
    mac_q.push_back('{32'd1, 32'd1, 32'd1, 32'd1});
    res_q.push_back(32'd2);
    send_cmd(16'd2);
    send_op(32'd1, 32'd1, 0); send_op(32'd1, 32'd1, 0);
    wait_res(base + 1);

    // len=1 negative accumulator: clamped only in the ReLU build
    base = res_seen;
    mac_q.push_back('{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0});
`ifdef MAC_SEQ_RELU_EN
    res_q.push_back(32'd0);
`else
    res_q.push_back(32'hFFFF_FFFF);
`endif
    send_cmd(16'd1);
    send_op(32'hFFFF_FFFF, 32'd1, 0);
    wait_res(base + 1);

    repeat (3) @(negedge clock);
    check("end_mac_q_drained", mac_q.size(), 0);
    check("end_res_q_drained", res_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mac_job_sequencer.md
Name: mac_job_sequencer

Overview:
- Sequences dot-product jobs onto the shared 2-lane MAC unit used by the CNN accelerator. Each MAC operation computes x*y + x2*y2.
- Accepts a job command (element count) and then a stream of operand pairs. Packs the pairs two at a time into MAC operations and handshakes with the MAC.
- Accumulates the partial sums and returns one result per job.
- Sits between the MMIO/DMA operand feeder and the MAC datapath.

Parameters:
- WIDTH, 32, operand, product and accumulator width in bits.
- LEN_W, 16, width of the job length field.

Ports:
- clock  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  job command valid.
- cmd_ready  output  1  sequencer can accept a job.
- cmd_len  input  LEN_W  number of (a,b) pairs in the job.
- op_valid  input  1  operand pair valid.
- op_ready  output  1  sequencer accepts an operand pair.
- op_a  input  WIDTH  operand a.
- op_b  input  WIDTH  operand b.
- mac_in_valid  output  1  MAC operation request.
- mac_in_ready  input  1  MAC is idle and accepts the request.
- mac_x, mac_y, mac_x2, mac_y2  output  WIDTH each  MAC operands.
- mac_out_valid  input  1  MAC result valid.
- mac_out_ready  output  1  sequencer accepts the MAC result.
- mac_result  input  WIDTH  x*y + x2*y2 from the MAC. The MAC prev input is tied to 0 at integration.
- res_valid  output  1  job result valid.
- res_ready  input  1  consumer accepts the job result.
- res_data  output  WIDTH  accumulated dot product.
- busy  output  1  a job is in progress (state != IDLE).

Behaviour:
- Clock is clock. Reset is reset: synchronous, active-high.
- Reset state: IDLE. All outputs are 0, except cmd_ready = 1 (it is combinational from IDLE). Accumulator, remaining count and operand registers are cleared to 0.
- A transfer happens on any valid&&ready in the same rising edge. All ready/valid outputs are decoded from state only, with no combinational path from inputs.

States:
- IDLE:
  - cmd_ready=1.
  - On cmd transfer: remaining <= cmd_len, acc <= 0.
  - If cmd_len==0, go to DONE. Otherwise go to LOAD0.
- LOAD0:
  - op_ready=1.
  - On transfer: mac_x<=op_a, mac_y<=op_b, remaining<=remaining-1.
  - If remaining==1 (odd tail): mac_x2<=0, mac_y2<=0, go to ISSUE. Otherwise go to LOAD1.
- LOAD1:
  - op_ready=1.
  - On transfer: mac_x2<=op_a, mac_y2<=op_b, remaining<=remaining-1, go to ISSUE.
- ISSUE:
  - mac_in_valid=1. Operand outputs are held stable.
  - On mac_in_ready, go to WAIT.
- WAIT:
  - mac_out_ready=1.
  - On mac_out_valid: acc <= acc + mac_result, modulo 2^WIDTH.
  - If remaining==0, go to DONE. Otherwise go to LOAD0.
- DONE:
  - res_valid=1, res_data=acc (post-ReLU if enabled).
  - Held until res_ready, then go to IDLE.

Arithmetic, ordering and boundary rules:
- All arithmetic is unsigned, and the accumulator wraps silently.
- Operand pairs are issued in arrival order: the first pair of each MAC operation goes to x/y, the second to x2/y2.
- Number of MAC operations = ceil(cmd_len/2).
- op_valid while not in LOAD0/LOAD1 is ignored (op_ready=0). Gaps in op_valid stall without a state change.
- A new cmd is not accepted until the result handshake completes, so jobs never overlap.
- mac_out_valid outside WAIT is ignored.
- Reset mid-job: the job is abandoned, no result is produced, and the sequencer returns to IDLE next cycle. The MAC shares the same reset.
- Minimum latency, cmd transfer to res_valid, for len=2 with an always-ready MAC and no operand gaps: 1 (LOAD0) + 1 (LOAD1) + 1 (ISSUE) + MAC latency + 1 (DONE entry).

Optional Feature:
- Macro: MAC_SEQ_RELU_EN.
- When defined: res_data = acc[WIDTH-1] ? 0 : acc. The accumulator is treated as two's complement for this check only.
- When undefined: res_data = acc unmodified.
- The state machine and timing are identical in both builds.

Test Plan:
- len=4, pairs (1,2),(3,4),(5,6),(7,8) -> exactly 2 MAC ops, carrying (1,2,3,4) then (5,6,7,8); res_data=100, one res_valid pulse.
- len=3, pairs (2,3),(4,5),(6,7) -> second MAC op has x2=y2=0; res_data=68.
- len=0 -> no op_ready, no mac_in_valid; res_valid the cycle after the cmd transfer, with res_data=0.
- len=2, res_ready held low 10 cycles -> res_valid and res_data stable, cmd_ready=0 throughout; IDLE the cycle after res_ready rises.
- len=4, reset asserted while in WAIT of the first op -> next cycle state IDLE, busy=0, no res_valid; a following len=2 job of (1,1),(1,1) returns 2.
- MAC_SEQ_RELU_EN, len=1, pair (0xFFFFFFFF,1) -> res_data=0; without the macro, res_data=0xFFFFFFFF.
